ex_mem_lsu_reg: RTL and testbench

- EX/MEM pipeline register plus load/store sequencer: the upstream producer of the MEM->WB valid/allow_in handshake.
- Latches the EX-stage bundle and issues one data-memory request per load/store on a valid/ready request channel.
- Waits for load data, then formats the byte/half/word result.
- Drives mem_to_wb_reg_valid and mem_stage_data into the WB register, honouring mem_wb_reg_allow_in backpressure.

---
 rtl/ex_mem_lsu_reg.sv | 161 ++++++++++++++++
 tb/tb_ex_mem_lsu_reg.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_lsu_reg.sv
// EX/MEM pipeline register with a load/store sequencer.
// Holds one EX bundle, issues at most one data-memory request for it,
// formats the load result and presents the finished bundle to the WB register.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | no memory work pending (empty stage or non-memory bundle)
//   S_REQ  | request presented on dmem_req_*, waiting for dmem_req_ready
//   S_WAIT | load accepted by memory, waiting for dmem_resp_valid
//   S_DONE | result complete, waiting for the WB register to take it
module ex_mem_lsu_reg #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [106:0]    ex_stage_data,
    input  logic            ex_to_mem_reg_valid,
    output logic            ex_mem_reg_allow_in,
    output logic            mem_to_wb_reg_valid,
    input  logic            mem_wb_reg_allow_in,
    output logic [69:0]     mem_stage_data,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_req_we,
    output logic [XLEN-1:0] dmem_req_addr,
    output logic [XLEN-1:0] dmem_req_wdata,
    output logic [3:0]      dmem_req_wstrb,
    input  logic            dmem_resp_valid,
    input  logic [XLEN-1:0] dmem_resp_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              valid_q;
    logic [106:0]      bundle_q;
    logic [XLEN-1:0]   load_q;

    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   rs2_data;
    logic [4:0]        rd;
    logic              rf_we;
    logic              mem_read;
    logic              mem_write;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   pc;

    logic              is_load;
    logic              is_store;
    logic              ready_go;
    logic [3:0]        store_strb;
    logic [XLEN-1:0]   store_data;
    logic [7:0]        load_byte;
    logic [15:0]       load_half;
    logic [XLEN-1:0]   load_fmt;

    assign alu_result = bundle_q[31:0];
    assign rs2_data   = bundle_q[63:32];
    assign rd         = bundle_q[68:64];
    assign rf_we      = bundle_q[69];
    assign mem_read   = bundle_q[70];
    assign mem_write  = bundle_q[71];
    assign funct3     = bundle_q[74:72];
    assign pc         = bundle_q[106:75];

    // A bundle with both mem_read and mem_write set is handled as a load.
    assign is_load  = mem_read;
    assign is_store = mem_write & ~mem_read;

    assign ready_go            = ((state_q == S_IDLE) && !(mem_read || mem_write)) ||
                                 (state_q == S_DONE);
    assign ex_mem_reg_allow_in = !valid_q || (ready_go && mem_wb_reg_allow_in);
    assign mem_to_wb_reg_valid = valid_q && ready_go;

    assign dmem_req_valid = (state_q == S_REQ);
    assign dmem_req_we    = is_store;
    assign dmem_req_addr  = {alu_result[31:2], 2'b00};
    assign dmem_req_wdata = store_data;
    assign dmem_req_wstrb = is_store ? store_strb : 4'b0000;

    assign mem_stage_data = {pc, rf_we, rd, (is_load ? load_q : alu_result)};

    // Store lane placement; unlisted funct3 codes fall back to a full word.
    always_comb begin
        store_strb = 4'b1111;
        store_data = rs2_data;
        case (funct3)
            3'b000: begin
                store_strb = 4'b0001 << alu_result[1:0];
                store_data = {4{rs2_data[7:0]}};
            end
            3'b001: begin
                store_strb = alu_result[1] ? 4'b1100 : 4'b0011;
                store_data = {2{rs2_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane extraction and sign/zero extension; addr[0] is ignored for halves.
    always_comb begin
        load_byte = 8'h00;
        case (alu_result[1:0])
            2'd0:    load_byte = dmem_resp_rdata[7:0];
            2'd1:    load_byte = dmem_resp_rdata[15:8];
            2'd2:    load_byte = dmem_resp_rdata[23:16];
            default: load_byte = dmem_resp_rdata[31:24];
        endcase
        load_half = alu_result[1] ? dmem_resp_rdata[31:16] : dmem_resp_rdata[15:0];
        load_fmt  = dmem_resp_rdata;
        case (funct3)
            3'b000:  load_fmt = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_fmt = {{16{load_half[15]}}, load_half};
            3'b100:  load_fmt = {24'h000000, load_byte};
            3'b101:  load_fmt = {16'h0000, load_half};
            default: load_fmt = dmem_resp_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state: a capture (or emptying) of the stage overrides sequencing.
    always_comb begin
        state_d = state_q;
        if (ex_mem_reg_allow_in) begin
            if (ex_to_mem_reg_valid &&
                (ex_stage_data[70] || ex_stage_data[71])) state_d = S_REQ;
            else                                          state_d = S_IDLE;
        end else begin
            case (state_q)
                S_REQ:   if (dmem_req_ready) state_d = is_load ? S_WAIT : S_DONE;
                S_WAIT:  if (dmem_resp_valid) state_d = S_DONE;
                default: ;
            endcase
        end
    end

    // Stage valid, bundle capture and load-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            load_q   <= '0;
        end else begin
            if (ex_mem_reg_allow_in) valid_q <= ex_to_mem_reg_valid;
            if (ex_mem_reg_allow_in && ex_to_mem_reg_valid) bundle_q <= ex_stage_data;
            if ((state_q == S_WAIT) && dmem_resp_valid) load_q <= load_fmt;
        end
    end

endmodule

// File: tb/tb_ex_mem_lsu_reg.sv
// Directed bench for ex_mem_lsu_reg: inputs are driven and outputs sampled on
// the falling edge, the design updates on the rising edge.
module tb_ex_mem_lsu_reg;

    logic         clk = 1'b0;
    logic         reset;
    logic [106:0] ex_stage_data;
    logic         ex_to_mem_reg_valid;
    logic         ex_mem_reg_allow_in;
    logic         mem_to_wb_reg_valid;
    logic         mem_wb_reg_allow_in;
    logic [69:0]  mem_stage_data;
    logic         dmem_req_valid;
    logic         dmem_req_ready;
    logic         dmem_req_we;
    logic [31:0]  dmem_req_addr;
    logic [31:0]  dmem_req_wdata;
    logic [3:0]   dmem_req_wstrb;
    logic         dmem_resp_valid;
    logic [31:0]  dmem_resp_rdata;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    ex_mem_lsu_reg #(.XLEN(32)) dut (
        .clk                 (clk),
        .reset               (reset),
        .ex_stage_data       (ex_stage_data),
        .ex_to_mem_reg_valid (ex_to_mem_reg_valid),
        .ex_mem_reg_allow_in (ex_mem_reg_allow_in),
        .mem_to_wb_reg_valid (mem_to_wb_reg_valid),
        .mem_wb_reg_allow_in (mem_wb_reg_allow_in),
        .mem_stage_data      (mem_stage_data),
        .dmem_req_valid      (dmem_req_valid),
        .dmem_req_ready      (dmem_req_ready),
        .dmem_req_we         (dmem_req_we),
        .dmem_req_addr       (dmem_req_addr),
        .dmem_req_wdata      (dmem_req_wdata),
        .dmem_req_wstrb      (dmem_req_wstrb),
        .dmem_resp_valid     (dmem_resp_valid),
        .dmem_resp_rdata     (dmem_resp_rdata)
    );

    function automatic logic [106:0] mk(input logic [31:0] pc, input logic [2:0] f3,
                                        input logic mw, input logic mr, input logic we,
                                        input logic [4:0] rd, input logic [31:0] rs2,
                                        input logic [31:0] alu);
        return {pc, f3, mw, mr, we, rd, rs2, alu};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        ex_stage_data = '0;
        ex_to_mem_reg_valid = 1'b0;
        mem_wb_reg_allow_in = 1'b1;
        dmem_req_ready = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = '0;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if (mem_to_wb_reg_valid !== 1'b0 || dmem_req_valid !== 1'b0 ||
            ex_mem_reg_allow_in !== 1'b1 || mem_stage_data !== 70'd0 ||
            dmem_req_wstrb !== 4'd0 || dmem_req_we !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset: wb_valid=%b req_valid=%b allow_in=%b data=%h strb=%b we=%b, want 0 0 1 0 0 0",
                     mem_to_wb_reg_valid, dmem_req_valid, ex_mem_reg_allow_in,
                     mem_stage_data, dmem_req_wstrb, dmem_req_we);
        end
        reset = 1'b0;
    endtask

    task automatic test_alu();
        logic [69:0] exp_data;
        exp_data = {32'h0000_0100, 1'b1, 5'd5, 32'h1234_5678};
        ex_stage_data = mk(32'h100, 3'b000, 1'b0, 1'b0, 1'b1, 5'd5, 32'hFFFF_FFFF, 32'h1234_5678);
        ex_to_mem_reg_valid = 1'b1;
        @(negedge clk);
        ex_to_mem_reg_valid = 1'b0;
        vec_cnt++;
        if (mem_to_wb_reg_valid !== 1'b1 || mem_stage_data !== exp_data || dmem_req_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL alu_out: wb_valid=%b data=%h req_valid=%b, want 1 %h 0",
                     mem_to_wb_reg_valid, mem_stage_data, dmem_req_valid, exp_data);
        end
        @(negedge clk);
        vec_cnt++;
        if (mem_to_wb_reg_valid !== 1'b0 || ex_mem_reg_allow_in !== 1'b1) begin
            err_cnt++;
            $display("FAIL alu_drain: wb_valid=%b allow_in=%b, want 0 1",
                     mem_to_wb_reg_valid, ex_mem_reg_allow_in);
        end
    endtask

    task automatic test_load(input logic [2:0] f3, input logic [31:0] addr, input logic both,
                             input logic [31:0] rdata, input logic [31:0] exp_wb, input string name);
        logic [69:0] exp_data;
        exp_data = {32'h0000_0200, 1'b1, 5'd7, exp_wb};
        ex_stage_data = mk(32'h200, f3, both, 1'b1, 1'b1, 5'd7, 32'h1357_9BDF, addr);
        ex_to_mem_reg_valid = 1'b1;
        dmem_req_ready = 1'b1;
        @(negedge clk);
        ex_to_mem_reg_valid = 1'b0;
        vec_cnt++;
        if (dmem_req_valid !== 1'b1 || dmem_req_addr !== {addr[31:2], 2'b00} ||
            dmem_req_wstrb !== 4'd0 || dmem_req_we !== 1'b0 ||
            mem_to_wb_reg_valid !== 1'b0 || ex_mem_reg_allow_in !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s req: valid=%b addr=%h strb=%b we=%b wb_valid=%b allow_in=%b, want 1 %h 0000 0 0 0",
                     name, dmem_req_valid, dmem_req_addr, dmem_req_wstrb, dmem_req_we,
                     mem_to_wb_reg_valid, ex_mem_reg_allow_in, {addr[31:2], 2'b00});
        end
        @(negedge clk);
        dmem_req_ready = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = rdata;
        vec_cnt++;
        if (dmem_req_valid !== 1'b0 || mem_to_wb_reg_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s wait: req_valid=%b wb_valid=%b, want 0 0",
                     name, dmem_req_valid, mem_to_wb_reg_valid);
        end
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = 32'h0;
        vec_cnt++;
        if (mem_to_wb_reg_valid !== 1'b1 || mem_stage_data !== exp_data) begin
            err_cnt++;
            $display("FAIL %s result: wb_valid=%b data=%h, want 1 %h",
                     name, mem_to_wb_reg_valid, mem_stage_data, exp_data);
        end
        @(negedge clk);
        vec_cnt++;
        if (mem_to_wb_reg_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s drain: wb_valid=%b, want 0", name, mem_to_wb_reg_valid);
        end
    endtask

    task automatic test_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                              input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                              input int stall, input string name);
        logic [69:0] exp_data;
        exp_data = {32'h0000_0300, 1'b0, 5'd0, addr};
        ex_stage_data = mk(32'h300, f3, 1'b1, 1'b0, 1'b0, 5'd0, rs2, addr);
        ex_to_mem_reg_valid = 1'b1;
        dmem_req_ready = 1'b0;
        for (int k = 0; k <= stall; k++) begin
            @(negedge clk);
            ex_to_mem_reg_valid = 1'b0;
            vec_cnt++;
            if (dmem_req_valid !== 1'b1 || dmem_req_we !== 1'b1 || dmem_req_wstrb !== exp_strb ||
                dmem_req_wdata !== exp_wdata || dmem_req_addr !== {addr[31:2], 2'b00} ||
                ex_mem_reg_allow_in !== 1'b0 || mem_to_wb_reg_valid !== 1'b0) begin
                err_cnt++;
                $display("FAIL %s req[%0d]: valid=%b we=%b strb=%b wdata=%h addr=%h allow_in=%b wb_valid=%b, want 1 1 %b %h %h 0 0",
                         name, k, dmem_req_valid, dmem_req_we, dmem_req_wstrb, dmem_req_wdata,
                         dmem_req_addr, ex_mem_reg_allow_in, mem_to_wb_reg_valid,
                         exp_strb, exp_wdata, {addr[31:2], 2'b00});
            end
            if (k == stall) dmem_req_ready = 1'b1;
        end
        @(negedge clk);
        dmem_req_ready = 1'b0;
        vec_cnt++;
        if (mem_to_wb_reg_valid !== 1'b1 || mem_stage_data !== exp_data || dmem_req_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s done: wb_valid=%b data=%h req_valid=%b, want 1 %h 0",
                     name, mem_to_wb_reg_valid, mem_stage_data, dmem_req_valid, exp_data);
        end
        @(negedge clk);
        vec_cnt++;
        if (mem_to_wb_reg_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s drain: wb_valid=%b, want 0", name, mem_to_wb_reg_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [69:0] exp_load;
        logic [69:0] exp_alu;
        exp_load = {32'h0000_0500, 1'b1, 5'd9, 32'hCAFE_F00D};
        exp_alu  = {32'h0000_0600, 1'b1, 5'd3, 32'h0000_0055};
        mem_wb_reg_allow_in = 1'b0;
        ex_stage_data = mk(32'h500, 3'b010, 1'b0, 1'b1, 1'b1, 5'd9, 32'h0, 32'h400);
        ex_to_mem_reg_valid = 1'b1;
        dmem_req_ready = 1'b1;
        @(negedge clk);
        ex_to_mem_reg_valid = 1'b0;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            vec_cnt++;
            if (mem_to_wb_reg_valid !== 1'b1 || mem_stage_data !== exp_load || ex_mem_reg_allow_in !== 1'b0) begin
                err_cnt++;
                $display("FAIL bp_hold[%0d]: wb_valid=%b data=%h allow_in=%b, want 1 %h 0",
                         k, mem_to_wb_reg_valid, mem_stage_data, ex_mem_reg_allow_in, exp_load);
            end
        end
        mem_wb_reg_allow_in = 1'b1;
        ex_stage_data = mk(32'h600, 3'b000, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0, 32'h55);
        ex_to_mem_reg_valid = 1'b1;
        #1;
        vec_cnt++;
        if (ex_mem_reg_allow_in !== 1'b1) begin
            err_cnt++;
            $display("FAIL bp_release: allow_in=%b, want 1", ex_mem_reg_allow_in);
        end
        @(negedge clk);
        ex_to_mem_reg_valid = 1'b0;
        vec_cnt++;
        if (mem_to_wb_reg_valid !== 1'b1 || mem_stage_data !== exp_alu) begin
            err_cnt++;
            $display("FAIL bp_next: wb_valid=%b data=%h, want 1 %h",
                     mem_to_wb_reg_valid, mem_stage_data, exp_alu);
        end
        @(negedge clk);
        vec_cnt++;
        if (mem_to_wb_reg_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL bp_drain: wb_valid=%b, want 0", mem_to_wb_reg_valid);
        end
    endtask

    task automatic test_reset_mid();
        ex_stage_data = mk(32'h700, 3'b010, 1'b0, 1'b1, 1'b1, 5'd11, 32'h0, 32'h700);
        ex_to_mem_reg_valid = 1'b1;
        dmem_req_ready = 1'b1;
        @(negedge clk);
        ex_to_mem_reg_valid = 1'b0;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vec_cnt++;
        if (mem_to_wb_reg_valid !== 1'b0 || dmem_req_valid !== 1'b0 ||
            ex_mem_reg_allow_in !== 1'b1 || mem_stage_data !== 70'd0) begin
            err_cnt++;
            $display("FAIL rst_mid: wb_valid=%b req_valid=%b allow_in=%b data=%h, want 0 0 1 0",
                     mem_to_wb_reg_valid, dmem_req_valid, ex_mem_reg_allow_in, mem_stage_data);
        end
        @(negedge clk);
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = 32'h0;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) @(negedge clk);
            vec_cnt++;
            if (mem_to_wb_reg_valid !== 1'b0 || dmem_req_valid !== 1'b0 || mem_stage_data !== 70'd0) begin
                err_cnt++;
                $display("FAIL rst_late_resp[%0d]: wb_valid=%b req_valid=%b data=%h, want 0 0 0",
                         k, mem_to_wb_reg_valid, dmem_req_valid, mem_stage_data);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [69:0] exp_data;
        ex_stage_data = mk(32'h1000, 3'b000, 1'b0, 1'b0, 1'b1, 5'd1, 32'h0, 32'h100);
        ex_to_mem_reg_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_data = {32'h1000 + 32'(4 * i), 1'b1, 5'(i + 1), 32'h100 + 32'(i)};
            vec_cnt++;
            if (mem_to_wb_reg_valid !== 1'b1 || mem_stage_data !== exp_data) begin
                err_cnt++;
                $display("FAIL b2b[%0d]: wb_valid=%b data=%h, want 1 %h",
                         i, mem_to_wb_reg_valid, mem_stage_data, exp_data);
            end
            if (i < 3)
                ex_stage_data = mk(32'h1000 + 32'(4 * (i + 1)), 3'b000, 1'b0, 1'b0, 1'b1,
                                   5'(i + 2), 32'h0, 32'h100 + 32'(i + 1));
            else
                ex_to_mem_reg_valid = 1'b0;
        end
        @(negedge clk);
        vec_cnt++;
        if (mem_to_wb_reg_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_drain: wb_valid=%b, want 0", mem_to_wb_reg_valid);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load(3'b000, 32'h1003, 1'b0, 32'h80FF_7F01, 32'hFFFF_FF80, "lb");
        test_load(3'b100, 32'h1003, 1'b0, 32'h80FF_7F01, 32'h0000_0080, "lbu");
        test_load(3'b001, 32'h1002, 1'b0, 32'h80FF_7F01, 32'hFFFF_80FF, "lh");
        test_load(3'b101, 32'h1001, 1'b0, 32'h80FF_7F01, 32'h0000_7F01, "lhu_mis");
        test_load(3'b010, 32'h1000, 1'b1, 32'h80FF_7F01, 32'h80FF_7F01, "lw_rw");
        test_load(3'b111, 32'h1001, 1'b0, 32'h80FF_7F01, 32'h80FF_7F01, "ld_undef");
        test_store(3'b001, 32'h2002, 32'hAAAA_BEEF, 4'b1100, 32'hBEEF_BEEF, 3, "sh");
        test_store(3'b000, 32'h2003, 32'h1234_565A, 4'b1000, 32'h5A5A_5A5A, 0, "sb");
        test_store(3'b010, 32'h2004, 32'hA5A5_0F0F, 4'b1111, 32'hA5A5_0F0F, 0, "sw");
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
